// File: rtl/ps2_kbd_device_tx.sv
// ps2_kbd_device_tx -- device-side PS/2 keyboard transmitter.
// Scancode bytes are queued in a small FIFO and sent one by one as 11-bit
// frames (start 0, data LSB first, odd parity, stop 1) on ps2_clk/ps2_data,
// with an idle gap between frames. Both bus lines are registered outputs.
// Optional feature macro: PS2_TX_BREAK_EN adds input wr_break, which queues
// 8'hF0 followed by wr_data as two entries in a single cycle.

module ps2_kbd_device_tx #(
    parameter int CLK_DIV    = 50,   // clk cycles per ps2_clk half-period
    parameter int FIFO_DEPTH = 8,    // byte queue depth, power of 2
    parameter int GAP_CYC    = 200   // idle clk cycles between frames
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
`ifdef PS2_TX_BREAK_EN
    input  logic       wr_break,
`endif
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       busy,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic [7:0] sent_cnt,
    output logic       overflow
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TMR_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX);

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_GAP
    } state_t;

    // Byte queue
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push_one;
    logic             push_two;
    logic             drop;
    logic             pop;
    logic [7:0]       rd_data;

    // Serialiser
    state_t           state_q;
    logic [TMR_W-1:0] timer_q;
    logic [3:0]       bit_q;
    logic [10:0]      shift_q;
    logic [7:0]       sent_q;
    logic             ps2_clk_q;
    logic             ps2_data_q;

    // The serialiser takes the head byte whenever it is idle and bytes wait.
    assign pop     = (state_q == ST_IDLE) && (count_q != '0);
    assign rd_data = mem_q[rd_ptr_q];

    // Classify this cycle's write request as a one-byte push, a two-byte
    // push or a drop, based on the room left in the queue.
    always_comb begin
        // NOTE: every variable gets a default first, so no latch is inferred.
        push_one = 1'b0;
        push_two = 1'b0;
        drop     = 1'b0;
`ifdef PS2_TX_BREAK_EN
        if (wr_en && wr_break) begin
            if (count_q > DEPTH_C - CNT_W'(2)) begin
                drop = 1'b1;
            end else begin
                push_two = 1'b1;
            end
        end else if (wr_en) begin
            if (count_q == DEPTH_C) begin
                drop = 1'b1;
            end else begin
                push_one = 1'b1;
            end
        end
`else
        if (wr_en) begin
            if (count_q == DEPTH_C) begin
                drop = 1'b1;
            end else begin
                push_one = 1'b1;
            end
        end
`endif
    end

    // A pop never frees room for a push in the same cycle: room is judged on
    // count_q alone, and a simultaneous push and pop leave the count unchanged.
    assign wr_ptr_d   = wr_ptr_q + PTR_W'({push_two, push_one});
    assign rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    assign count_d    = count_q + CNT_W'({push_two, push_one}) - CNT_W'(pop);
    assign overflow_d = overflow_q | drop;

    // Queue pointers, fill count and the sticky overflow flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every update
        // on an edge is computed from the values held before that edge.
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Queue storage writes; a break push lays down 8'hF0 ahead of the byte.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers and count
        // define which entries are valid, so stale bytes are never read.
        if (push_one) begin
            mem_q[wr_ptr_q] <= wr_data;
        end else if (push_two) begin
            mem_q[wr_ptr_q]              <= 8'hF0;
            mem_q[wr_ptr_q + PTR_W'(1)]  <= wr_data;
        end
    end

    // Frame FSM: IDLE pops and loads the frame, each bit spends CLK_DIV
    // cycles in SETUP (clock high) then CLK_DIV in LOW (clock low), then the
    // GAP holds both lines high. The bus lines are registered from the
    // current state, so they follow the state by one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bit_q      <= '0;
            shift_q    <= '1;
            sent_q     <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
        end else begin
            ps2_clk_q  <= (state_q != ST_LOW);
            ps2_data_q <= (state_q == ST_SETUP || state_q == ST_LOW) ? shift_q[0] : 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        shift_q <= {1'b1, ~^rd_data, rd_data, 1'b0};
                        bit_q   <= '0;
                        timer_q <= '0;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (timer_q == HALF_LAST) begin
                        timer_q <= '0;
                        state_q <= ST_LOW;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_LOW: begin
                    if (timer_q == HALF_LAST) begin
                        timer_q <= '0;
                        if (bit_q == 4'd10) begin
                            sent_q  <= sent_q + 8'd1;
                            state_q <= ST_GAP;
                        end else begin
                            bit_q   <= bit_q + 4'd1;
                            shift_q <= {1'b1, shift_q[10:1]};
                            state_q <= ST_SETUP;
                        end
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_GAP: begin
                    if (timer_q == GAP_LAST) begin
                        timer_q <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef PS2_TX_BREAK_EN
    assign full = (count_q > DEPTH_C - CNT_W'(2));
`else
    assign full = (count_q == DEPTH_C);
`endif
    assign busy     = (state_q != ST_IDLE) || (count_q != '0);
    assign ps2_clk  = ps2_clk_q;
    assign ps2_data = ps2_data_q;
    assign sent_cnt = sent_q;
    assign overflow = overflow_q;

endmodule
